// File: rtl/hydro_pkg.sv
// Shared types and constants for the hydrophone peak-detect sequencing controller.
package hydro_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, EXP_A, EXP_B} state_t;

    localparam logic BEAT_CH01 = 1'b0;
    localparam logic BEAT_CH23 = 1'b1;
    localparam int   DEF_SAMPLES_PER_WINDOW = 500;
    localparam int   LANE_W = 16;
endpackage

// File: rtl/hydro_frame_counter.sv
// Frame counter within a window: clear has priority over increment; flags first and last frame.
module hydro_frame_counter
    import hydro_pkg::*;
#(
    parameter int CNT_W              = 16,
    parameter int SAMPLES_PER_WINDOW = DEF_SAMPLES_PER_WINDOW
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_tc
);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SAMPLES_PER_WINDOW - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn || i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_tc   = (r_cnt == TC_VAL);
endmodule

// File: rtl/hydro_window_ctrl.sv
// Beat-phase FSM, window sequencing and result-slot handshake for the 4-channel
// running-max datapath; framing errors and lost windows are flagged sticky.
module hydro_window_ctrl
    import hydro_pkg::*;
#(
    parameter int SAMPLES_PER_WINDOW = DEF_SAMPLES_PER_WINDOW,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             acc_en,
    output logic             acc_sel,
    output logic             acc_load,
    output logic             win_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr,
    output logic [CNT_W-1:0] win_count
);
    state_t           r_state;
    logic             r_win_end;
    logic             r_res_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_win_count;

    logic             w_acc, w_cap_a, w_cap_b, w_err, w_win_end, w_slot_free;
    logic             w_zero, w_tc;
    logic [CNT_W-1:0] w_frame_cnt;

    // The stream is never back-pressured; unused beats are simply dropped.
    assign s_axis_tready = resetn;
    assign w_acc         = s_axis_tvalid && s_axis_tready;

    assign w_cap_a   = w_acc && (r_state == EXP_A) && !s_axis_tlast;
    assign w_cap_b   = w_acc && (r_state == EXP_B) &&  s_axis_tlast;
    assign w_err     = w_acc && (((r_state == EXP_A) &&  s_axis_tlast) ||
                                 ((r_state == EXP_B) && !s_axis_tlast));
    assign w_win_end = w_cap_b && w_tc;

    assign acc_en   = w_cap_a || w_cap_b;
    assign acc_sel  = w_cap_b ? BEAT_CH23 : BEAT_CH01;
    assign acc_load = acc_en && w_zero;

    hydro_frame_counter #(
        .CNT_W              (CNT_W),
        .SAMPLES_PER_WINDOW (SAMPLES_PER_WINDOW)
    ) u_frame_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (!enable || w_err || w_win_end),
        .i_inc  (w_cap_b),
        .o_cnt  (w_frame_cnt),
        .o_zero (w_zero),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!resetn || !enable)
            r_state <= IDLE;
        else begin
            case (r_state)
                IDLE:    r_state <= SYNC;
                SYNC:    if (w_acc && s_axis_tlast) r_state <= EXP_A;
                EXP_A:   if (w_cap_a) r_state <= EXP_B;
                EXP_B:   if (w_cap_b) r_state <= EXP_A;
                         else if (w_err) r_state <= SYNC;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A slot being consumed in the same cycle counts as free, so windows can
    // be handed over back-to-back without an overrun.
    assign w_slot_free = !r_res_valid || res_ready;
    assign win_done    = r_win_end && w_slot_free;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_win_end   <= 1'b0;
            r_res_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_win_count <= '0;
        end else begin
            r_win_end <= w_win_end;
            if (win_done)
                r_res_valid <= 1'b1;
            else if (res_ready)
                r_res_valid <= 1'b0;
            if (win_done)
                r_win_count <= r_win_count + 1'b1;
            if (w_err)
                r_frame_err <= 1'b1;
            else if (err_clr)
                r_frame_err <= 1'b0;
            if (r_win_end && !w_slot_free)
                r_overrun <= 1'b1;
            else if (err_clr)
                r_overrun <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign win_count = r_win_count;
endmodule

// File: tb/tb_hydro_window_ctrl.sv
// Directed bench for hydro_window_ctrl with a 4-frame window.
module tb_hydro_window_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        acc_en, acc_sel, acc_load, win_done, res_valid;
    logic        res_ready = 1'b0;
    logic        frame_err, overrun;
    logic        err_clr = 1'b0;
    logic [15:0] win_count;

    int checks = 0;
    int errors = 0;

    hydro_window_ctrl #(.SAMPLES_PER_WINDOW(4), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .acc_en(acc_en), .acc_sel(acc_sel), .acc_load(acc_load), .win_done(win_done),
        .res_valid(res_valid), .res_ready(res_ready), .frame_err(frame_err), .overrun(overrun),
        .err_clr(err_clr), .win_count(win_count)
    );

    always #5 clk = ~clk;

    // Cycle monitor: samples 2 time units after the falling edge, once inputs are settled.
    int cyc = 0, cnt_acc = 0, cnt_load = 0, cnt_wd = 0, cnt_rv = 0, last_acc_cyc = 0, wd_cyc = 0;
    bit log_load [256];
    bit log_sel  [256];
    always @(negedge clk) begin
        #2;
        cyc++;
        if (acc_en) begin
            log_load[cnt_acc % 256] = acc_load;
            log_sel[cnt_acc % 256]  = acc_sel;
            cnt_acc++;
            cnt_load += int'(acc_load);
            last_acc_cyc = cyc;
        end
        if (win_done) begin
            cnt_wd++;
            wd_cyc = cyc;
        end
        if (res_valid) cnt_rv++;
    end

    int a0, l0, w0, r0, a1;

    task automatic drive(input logic v, input logic l);
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tlast  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic send(input logic l, input int gap);
        repeat (gap) drive(1'b0, 1'b0);
        drive(1'b1, l);
    endtask

    task automatic frames(input int n, input int gap);
        repeat (n) begin
            send(1'b0, gap);
            send(1'b1, gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        res_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Enable, let IDLE->SYNC happen, then sync on a lone B beat.
    task automatic start_sync(input logic rdy);
        enable = 1'b1;
        res_ready = rdy;
        idle(1);
        send(1'b1, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #2;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready_low: got %b exp 0", s_axis_tready); end
        repeat (2) @(negedge clk);
        #2;
        checks++; if ({acc_en, acc_sel, acc_load, win_done, res_valid, frame_err, overrun} !== 7'b0) begin errors++; $display("FAIL rst_outputs: got %b exp 0", {acc_en, acc_sel, acc_load, win_done, res_valid, frame_err, overrun}); end
        resetn = 1'b1;
        @(negedge clk); #3;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_high: got %b exp 1", s_axis_tready); end
        checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL rst_win_count: got %0d exp 0", win_count); end
    endtask

    task automatic test_basic();
        do_reset();
        start_sync(1'b1);
        a0 = cnt_acc; l0 = cnt_load; w0 = cnt_wd; r0 = cnt_rv;
        frames(4, 0);
        idle(3); #3;
        checks++; if (cnt_acc - a0 !== 8) begin errors++; $display("FAIL basic_acc_en: got %0d exp 8", cnt_acc - a0); end
        checks++; if (cnt_load - l0 !== 2) begin errors++; $display("FAIL basic_load_count: got %0d exp 2", cnt_load - l0); end
        checks++; if ({log_load[a0], log_load[a0+1]} !== 2'b11) begin errors++; $display("FAIL basic_load_first: got %b exp 11", {log_load[a0], log_load[a0+1]}); end
        checks++; if ({log_sel[a0], log_sel[a0+1]} !== 2'b01) begin errors++; $display("FAIL basic_sel: got %b exp 01", {log_sel[a0], log_sel[a0+1]}); end
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL basic_win_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (wd_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL basic_wd_timing: got %0d exp %0d", wd_cyc, last_acc_cyc + 1); end
        checks++; if (cnt_rv - r0 !== 1) begin errors++; $display("FAIL basic_res_valid_len: got %0d exp 1", cnt_rv - r0); end
        checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL basic_win_count: got %0d exp 1", win_count); end
    endtask

    task automatic test_gapped();
        do_reset();
        start_sync(1'b1);
        a0 = cnt_acc; l0 = cnt_load; w0 = cnt_wd;
        frames(8, 2);
        idle(3); #3;
        checks++; if (cnt_acc - a0 !== 16) begin errors++; $display("FAIL gap_acc_en: got %0d exp 16", cnt_acc - a0); end
        checks++; if (cnt_wd - w0 !== 2) begin errors++; $display("FAIL gap_win_done: got %0d exp 2", cnt_wd - w0); end
        checks++; if (cnt_load - l0 !== 4) begin errors++; $display("FAIL gap_load_count: got %0d exp 4", cnt_load - l0); end
        checks++; if ({log_load[a0+8], log_load[a0+9]} !== 2'b11) begin errors++; $display("FAIL gap_load_win2: got %b exp 11", {log_load[a0+8], log_load[a0+9]}); end
        checks++; if (win_count !== 16'd2) begin errors++; $display("FAIL gap_win_count: got %0d exp 2", win_count); end
    endtask

    task automatic test_frame_aa();
        do_reset();
        start_sync(1'b1);
        a0 = cnt_acc; w0 = cnt_wd;
        send(1'b0, 0);
        send(1'b0, 0);
        idle(1); #3;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL aa_frame_err: got %b exp 1", frame_err); end
        checks++; if (cnt_acc - a0 !== 1) begin errors++; $display("FAIL aa_second_a: got %0d exp 1", cnt_acc - a0); end
        send(1'b0, 0);
        idle(1); #3;
        checks++; if (cnt_acc - a0 !== 1) begin errors++; $display("FAIL aa_sync_discard: got %0d exp 1", cnt_acc - a0); end
        send(1'b1, 0);
        frames(4, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL aa_win_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (cnt_acc - a0 !== 9) begin errors++; $display("FAIL aa_acc_total: got %0d exp 9", cnt_acc - a0); end
        checks++; if (log_load[a0+1] !== 1'b1) begin errors++; $display("FAIL aa_load: got %b exp 1", log_load[a0+1]); end
        checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL aa_win_count: got %0d exp 1", win_count); end
    endtask

    task automatic test_frame_abb();
        do_reset();
        start_sync(1'b1);
        a0 = cnt_acc; l0 = cnt_load; w0 = cnt_wd;
        send(1'b0, 0);
        send(1'b1, 0);
        send(1'b1, 0);
        idle(1); #3;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abb_frame_err: got %b exp 1", frame_err); end
        checks++; if (cnt_acc - a0 !== 2) begin errors++; $display("FAIL abb_acc: got %0d exp 2", cnt_acc - a0); end
        frames(3, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 0) begin errors++; $display("FAIL abb_no_early_done: got %0d exp 0", cnt_wd - w0); end
        checks++; if ({log_load[a0+2], log_load[a0+3]} !== 2'b11) begin errors++; $display("FAIL abb_load: got %b exp 11", {log_load[a0+2], log_load[a0+3]}); end
        frames(1, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL abb_win_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (cnt_load - l0 !== 4) begin errors++; $display("FAIL abb_load_count: got %0d exp 4", cnt_load - l0); end
        checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL abb_win_count: got %0d exp 1", win_count); end
    endtask

    task automatic test_overrun();
        do_reset();
        start_sync(1'b0);
        w0 = cnt_wd;
        frames(4, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL ovr_first_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ovr_res_valid: got %b exp 1", res_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_not_yet: got %b exp 0", overrun); end
        frames(4, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL ovr_second_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
        checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL ovr_win_count: got %0d exp 1", win_count); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #3;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ovr_result_kept: got %b exp 1", res_valid); end
        res_ready = 1'b1;
        idle(2); #3;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ovr_consumed: got %b exp 0", res_valid); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        start_sync(1'b1);
        w0 = cnt_wd;
        frames(3, 0);
        @(negedge clk); enable = 1'b0; s_axis_tvalid = 1'b0;
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 0) begin errors++; $display("FAIL en_partial_done: got %0d exp 0", cnt_wd - w0); end
        start_sync(1'b1);
        a1 = cnt_acc;
        frames(3, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 0) begin errors++; $display("FAIL en_restart_count: got %0d exp 0", cnt_wd - w0); end
        checks++; if ({log_load[a1], log_load[a1+1]} !== 2'b11) begin errors++; $display("FAIL en_restart_load: got %b exp 11", {log_load[a1], log_load[a1+1]}); end
        frames(1, 0);
        idle(3); #3;
        checks++; if (cnt_wd - w0 !== 1) begin errors++; $display("FAIL en_full_done: got %0d exp 1", cnt_wd - w0); end
        checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL en_win_count: got %0d exp 1", win_count); end
        // Reset in the middle of a window with a beat A presented.
        frames(2, 0);
        @(negedge clk);
        resetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        @(negedge clk); #2;
        checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL midrst_win_count: got %0d exp 0", win_count); end
        checks++; if ({s_axis_tready, acc_en, acc_load, win_done, res_valid, frame_err, overrun} !== 7'b0) begin errors++; $display("FAIL midrst_outputs: got %b exp 0", {s_axis_tready, acc_en, acc_load, win_done, res_valid, frame_err, overrun}); end
        s_axis_tvalid = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_frame_aa();
        test_frame_abb();
        test_overrun();
        test_enable_drop();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
